// File: rtl/packed_sat_shift_pkg.sv
// Shared types and lane geometry helpers for the packed saturating shift unit.
// Lane layout is derived from lane_e and the datapath width.
package packed_sat_shift_pkg;

    localparam int MAXXLEN = 64;

    typedef enum logic [1:0] {
        OP_KSLL = 2'b00,
        OP_SLL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_SRL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        LANE_8  = 2'b00,
        LANE_16 = 2'b01,
        LANE_32 = 2'b10,
        LANE_X  = 2'b11
    } lane_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic int laneBits(lane_e lane, int xlen);
        int w;
        case (lane)
            LANE_8:  w = 8;
            LANE_16: w = 16;
            LANE_32: w = 32;
            default: w = xlen;
        endcase
        return w;
    endfunction

    function automatic logic [MAXXLEN-1:0] laneMsbMask(lane_e lane, int xlen);
        logic [MAXXLEN-1:0] m;
        int w;
        m = '0;
        w = laneBits(lane, xlen);
        for (int i = 0; i < MAXXLEN; i++) begin
            if (i < xlen && (i % w) == w - 1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/packed_sat_shift_unit_step.sv
// One single-bit shift step applied to every lane at once.
// Sat flags and original signs are kept at each lane's MSB position.
module sat_shift_step
    import packed_sat_shift_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] vec,
    input  op_e             op,
    input  lane_e           lane,
    input  logic [XLEN-1:0] sat,
    input  logic [XLEN-1:0] origSign,
    output logic [XLEN-1:0] vecNext,
    output logic [XLEN-1:0] satNext
);

    logic [XLEN-1:0] msb;
    logic [XLEN-1:0] lsb;
    logic [XLEN-1:0] shl;
    logic [XLEN-1:0] shr;
    logic [XLEN-1:0] hit;
    logic [XLEN-1:0] frozen;
    logic [XLEN-1:0] fresh;
    logic [XLEN-1:0] signFill;
    logic [XLEN-1:0] satVal;
    int              w;

    // Smear lane-MSB markers down across the whole lane.
    function automatic logic [XLEN-1:0] spread(logic [XLEN-1:0] m, int lw);
        logic [XLEN-1:0] r;
        r = m;
        for (int k = 1; k < XLEN; k = k * 2) begin
            if (k < lw) begin
                r = r | (r >> k);
            end
        end
        return r;
    endfunction

    always_comb begin
        w        = laneBits(lane, XLEN);
        msb      = XLEN'(laneMsbMask(lane, XLEN));
        lsb      = msb >> (w - 1);
        shl      = (vec << 1) & ~lsb;
        shr      = (vec >> 1) & ~msb;
        hit      = (vec ^ (vec << 1)) & msb & ~sat;
        if (op != OP_KSLL) begin
            hit = '0;
        end
        frozen   = spread(sat, w);
        fresh    = spread(hit, w);
        signFill = spread(origSign & msb, w);
        satVal   = ~(signFill ^ msb);
        satNext  = sat | hit;
        vecNext  = shl;
        unique case (op)
            OP_KSLL: vecNext = (frozen & vec)
                             | (fresh & satVal)
                             | (~frozen & ~fresh & shl);
            OP_SLL:  vecNext = shl;
            OP_SRA:  vecNext = shr | (vec & msb);
            OP_SRL:  vecNext = shr;
            default: vecNext = shl;
        endcase
    end

endmodule

// File: rtl/packed_sat_shift_unit.sv
// Iterative packed-SIMD shift unit: one bit position per cycle,
// start/done handshake, per-op saturation flag and sticky overflow.
module packed_sat_shift_unit
    import packed_sat_shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] srcA,
    input  logic [SHW-1:0]  shamt,
    input  logic            ovClear,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            opOv,
    output logic            ov
);

    state_e          state;
    state_e          stateNext;
    logic [SHW-1:0]  cnt;
    logic [SHW-1:0]  cntInit;
    logic [XLEN-1:0] vec;
    logic [XLEN-1:0] sat;
    logic [XLEN-1:0] origSign;
    logic [XLEN-1:0] startMsb;
    logic [XLEN-1:0] stepVec;
    logic [XLEN-1:0] stepSat;
    op_e             opR;
    lane_e           laneR;

    assign cntInit  = shamt & SHW'(laneBits(lane_e'(lane), XLEN) - 1);
    assign startMsb = XLEN'(laneMsbMask(lane_e'(lane), XLEN));

    sat_shift_step #(
        .XLEN(XLEN)
    ) uStep (
        .vec     (vec),
        .op      (opR),
        .lane    (laneR),
        .sat     (sat),
        .origSign(origSign),
        .vecNext (stepVec),
        .satNext (stepSat)
    );

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (cntInit == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == SHW'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            opOv     <= 1'b0;
            ov       <= 1'b0;
            cnt      <= '0;
            vec      <= '0;
            sat      <= '0;
            origSign <= '0;
            opR      <= OP_KSLL;
            laneR    <= LANE_8;
        end else begin
            state <= stateNext;
            busy  <= (stateNext != IDLE);
            done  <= (stateNext == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vec      <= srcA;
                        opR      <= op_e'(op);
                        laneR    <= lane_e'(lane);
                        cnt      <= cntInit;
                        sat      <= '0;
                        origSign <= srcA & startMsb;
                        if (cntInit == '0) begin
                            result <= srcA;
                            opOv   <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    vec <= stepVec;
                    sat <= stepSat;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result <= stepVec;
                        opOv   <= |stepSat;
                    end
                end
                default: ;
            endcase
            // A saturating completion beats a coincident clear.
            if (state == DONE && opOv) begin
                ov <= 1'b1;
            end else if (ovClear) begin
                ov <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packed_sat_shift_unit.sv
// Self-checking bench for packed_sat_shift_unit: directed table,
// hand-written corner sequences and randomized ops against a lane model.
module tb_packed_sat_shift_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  opIn;
    logic [1:0]  laneIn;
    logic [31:0] srcA;
    logic [4:0]  shamt;
    logic        ovClear;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        opOv;
    logic        ov;

    int nCmp = 0;
    int nBad = 0;
    bit ovModel = 0;

    packed_sat_shift_unit #(
        .XLEN(32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (opIn),
        .lane   (laneIn),
        .srcA   (srcA),
        .shamt  (shamt),
        .ovClear(ovClear),
        .busy   (busy),
        .done   (done),
        .result (result),
        .opOv   (opOv),
        .ov     (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          clr;
        logic [1:0]  op;
        logic [1:0]  lane;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] expRes;
        bit          expOv;
    } vec_t;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Lane model: plain integer arithmetic per lane.
    function automatic void refOp(input int op, input int lane,
                                  input logic [31:0] a, input int sh,
                                  output logic [31:0] r, output bit sat);
        int w, n;
        longint x, sx, v, lim, mask;
        w    = (lane == 0) ? 8 : (lane == 1) ? 16 : 32;
        n    = sh % w;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        r    = '0;
        sat  = 1'b0;
        for (int l = 0; l < 32 / w; l++) begin
            x  = (longint'(a) >> (l * w)) & mask;
            sx = (x >= lim) ? x - 2 * lim : x;
            case (op)
                0: begin
                    v = sx * (longint'(1) << n);
                    if (v > lim - 1) begin
                        v = lim - 1;
                        sat = 1'b1;
                    end else if (v < -lim) begin
                        v = -lim;
                        sat = 1'b1;
                    end
                end
                1: v = x << n;
                2: v = sx >>> n;
                default: v = x >> n;
            endcase
            r = r | (32'(v & mask) << (l * w));
        end
    endfunction

    function automatic int expLat(input int lane, input int sh);
        int w;
        w = (lane == 0) ? 8 : (lane == 1) ? 16 : 32;
        return (sh % w) + 1;
    endfunction

    task automatic pulseClear();
        ovClear = 1'b1;
        @(posedge clk);
        #1 ovClear = 1'b0;
        ovModel = 1'b0;
    endtask

    task automatic runOp(input logic [1:0] op, input logic [1:0] lane,
                         input logic [31:0] a, input logic [4:0] sh,
                         input bit clrAtDone,
                         output logic [31:0] res, output bit ovf,
                         output int lat);
        opIn   = op;
        laneIn = lane;
        srcA   = a;
        shamt  = sh;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        ovf = opOv;
        if (clrAtDone) ovClear = 1'b1;
        @(posedge clk);
        #1 ovClear = 1'b0;
        check("donePulse", {63'd0, done}, 64'd0);
    endtask

    vec_t        tbl[11];
    logic [31:0] res;
    logic [31:0] expR;
    bit          ovf;
    bit          expO;
    int          lat;
    int          nDone;

    initial begin
        tbl[0]  = '{0, 2'd0, 2'd0, 32'h40404040, 5'd1,  32'h7F7F7F7F, 1};
        tbl[1]  = '{1, 2'd0, 2'd0, 32'h10101010, 5'd2,  32'h40404040, 0};
        tbl[2]  = '{0, 2'd0, 2'd0, 32'hC0C0C0C0, 5'd3,  32'h80808080, 1};
        tbl[3]  = '{0, 2'd0, 2'd0, 32'hD0D0D0D0, 5'd1,  32'hA0A0A0A0, 0};
        tbl[4]  = '{0, 2'd0, 2'd1, 32'h00017FFF, 5'd4,  32'h00107FFF, 1};
        tbl[5]  = '{0, 2'd2, 2'd0, 32'h80F07F10, 5'd9,  32'hC0F83F08, 0};
        tbl[6]  = '{0, 2'd3, 2'd2, 32'h12345678, 5'd0,  32'h12345678, 0};
        tbl[7]  = '{0, 2'd1, 2'd1, 32'h8001C003, 5'd1,  32'h00028006, 0};
        tbl[8]  = '{0, 2'd3, 2'd3, 32'h80000000, 5'd31, 32'h00000001, 0};
        tbl[9]  = '{0, 2'd0, 2'd3, 32'hFFFFFFFF, 5'd31, 32'h80000000, 0};
        tbl[10] = '{0, 2'd1, 2'd0, 32'h01FF0203, 5'd15, 32'h80800080, 0};

        rst = 1'b1; start = 1'b0; opIn = '0; laneIn = '0;
        srcA = '0; shamt = '0; ovClear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rstBusy",   {63'd0, busy}, 64'd0);
        check("rstDone",   {63'd0, done}, 64'd0);
        check("rstResult", {32'd0, result}, 64'd0);
        check("rstOpOv",   {63'd0, opOv}, 64'd0);
        check("rstOv",     {63'd0, ov}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            if (tbl[i].clr) pulseClear();
            runOp(tbl[i].op, tbl[i].lane, tbl[i].a, tbl[i].sh, 0, res, ovf, lat);
            ovModel = ovModel | tbl[i].expOv;
            check($sformatf("tblRes%0d", i), {32'd0, res}, {32'd0, tbl[i].expRes});
            check($sformatf("tblOpOv%0d", i), {63'd0, ovf}, {63'd0, tbl[i].expOv});
            check($sformatf("tblLat%0d", i), 64'(lat),
                  64'(expLat(int'(tbl[i].lane), int'(tbl[i].sh))));
            check($sformatf("tblOv%0d", i), {63'd0, ov}, {63'd0, ovModel});
        end

        // Start pulses while busy must be ignored.
        refOp(0, 0, 32'h01020304, 5, expR, expO);
        opIn = 2'd0; laneIn = 2'd0; srcA = 32'h01020304; shamt = 5'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busyAfterStart", {63'd0, busy}, 64'd1);
        srcA = 32'h7F7F7F7F;
        shamt = 5'd1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        nDone = 0;
        res = '0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                nDone++;
                res = result;
                ovf = opOv;
            end
            @(posedge clk);
            #1;
        end
        ovModel = ovModel | expO;
        check("busyIgnoreDones", 64'(nDone), 64'd1);
        check("busyIgnoreRes", {32'd0, res}, {32'd0, expR});
        check("busyIgnoreOv", {63'd0, ov}, {63'd0, ovModel});

        // Reset in the middle of a 7-step op.
        opIn = 2'd3; laneIn = 2'd0; srcA = 32'hFFFFFFFF; shamt = 5'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midOpBusy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ovModel = 1'b0;
        check("abortBusy",   {63'd0, busy}, 64'd0);
        check("abortDone",   {63'd0, done}, 64'd0);
        check("abortResult", {32'd0, result}, 64'd0);
        check("abortOv",     {63'd0, ov}, 64'd0);
        nDone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) nDone++;
            @(posedge clk);
            #1;
        end
        check("abortNoDone", 64'(nDone), 64'd0);

        // Clear coinciding with a saturating completion: set wins.
        runOp(2'd0, 2'd0, 32'h40404040, 5'd1, 0, res, ovf, lat);
        check("preClearOv", {63'd0, ov}, 64'd1);
        pulseClear();
        check("clearedOv", {63'd0, ov}, 64'd0);
        runOp(2'd0, 2'd0, 32'h40404040, 5'd1, 1, res, ovf, lat);
        ovModel = 1'b1;
        check("setBeatsClear", {63'd0, ov}, 64'd1);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  rop;
            logic [1:0]  rlane;
            logic [31:0] ra;
            logic [4:0]  rsh;
            rop   = 2'($urandom_range(0, 3));
            rlane = 2'($urandom_range(0, 3));
            ra    = $urandom;
            rsh   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) pulseClear();
            refOp(int'(rop), int'(rlane), ra, int'(rsh), expR, expO);
            runOp(rop, rlane, ra, rsh, 0, res, ovf, lat);
            ovModel = ovModel | expO;
            check($sformatf("rndRes%0d", i), {32'd0, res}, {32'd0, expR});
            check($sformatf("rndOpOv%0d", i), {63'd0, ovf}, {63'd0, expO});
            check($sformatf("rndLat%0d", i), 64'(lat),
                  64'(expLat(int'(rlane), int'(rsh))));
            check($sformatf("rndOv%0d", i), {63'd0, ov}, {63'd0, ovModel});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
